// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and row-FSM state type for the conv window datapath.
package cnn_pkg;
  localparam int PIX_W = 8;
  localparam int KERNEL = 3;
  localparam int IMG_W = 64;
  typedef enum logic [1:0] {EXP0, EXP1, EXP2} row_state_t;
endpackage

// File: rtl/col_collector.sv
// col_collector: gathers three vertically ordered beats into one column and flags row-order errors.
module col_collector #(
  parameter int PIX_W = cnn_pkg::PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc,
  input  logic [PIX_W-1:0]     pix,
  input  logic                 zero,
  input  logic [1:0]           row,
  input  logic                 sol,
  output logic                 done,
  output logic                 line_start,
  output logic [3*PIX_W-1:0]   col,
  output logic                 err
);
  cnn_pkg::row_state_t state, state_nx;
  logic [PIX_W-1:0] pix_z, stg0, stg1;
  logic hit, miss;
  assign pix_z = zero ? '0 : pix;
  assign hit = acc && (row == state);
  assign miss = acc && (row != state);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= cnn_pkg::EXP0;
    else state <= state_nx;
  always_comb begin
    state_nx = miss ? cnn_pkg::EXP0 :
               !hit ? state :
               state == cnn_pkg::EXP0 ? cnn_pkg::EXP1 :
               state == cnn_pkg::EXP1 ? cnn_pkg::EXP2 : cnn_pkg::EXP0;
  end
  always_comb begin
    done = hit && state == cnn_pkg::EXP2;
    line_start = hit && sol && state == cnn_pkg::EXP0;
    col = {pix_z, stg1, stg0};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stg0 <= '0;
      stg1 <= '0;
      err <= 1'b0;
    end else if (miss) begin
      stg0 <= '0;
      stg1 <= '0;
      err <= 1'b1;
    end else if (hit && state == cnn_pkg::EXP0) stg0 <= pix_z;
    else if (hit && state == cnn_pkg::EXP1) stg1 <= pix_z;
endmodule

// File: rtl/conv_window_assembler.sv
// conv_window_assembler: builds sliding 3x3 windows from column beats with a valid/ready output.
module conv_window_assembler #(
  parameter int PIX_W = cnn_pkg::PIX_W,
  parameter int IMG_W = cnn_pkg::IMG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pix,
  input  logic                 in_zero,
  input  logic [1:0]           in_row,
  input  logic                 in_sol,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9*PIX_W-1:0]   out_win,
  output logic [6:0]           out_col,
  output logic                 err
);
  localparam int K = cnn_pkg::KERNEL;
  logic acc, done, line_start;
  logic [K*PIX_W-1:0] col;
  logic [K*K*PIX_W-1:0] win, win_nx;
  logic [1:0] cnt, cnt_nx;
  logic [6:0] idx;
  assign in_ready = !(out_valid && !out_ready);
  assign acc = in_valid && in_ready;
  assign out_win = win;
  col_collector #(.PIX_W(PIX_W)) u_col (
    .clk(clk), .rst(rst), .acc(acc), .pix(in_pix), .zero(in_zero), .row(in_row),
    .sol(in_sol), .done(done), .line_start(line_start), .col(col), .err(err)
  );
  always_comb begin
    cnt_nx = cnt == 2'd3 ? 2'd3 : cnt + 2'd1;
    win_nx = win;
    for (int r = 0; r < K; r++) begin
      for (int k = 0; k < K - 1; k++)
        win_nx[(K*r+k)*PIX_W +: PIX_W] = win[(K*r+k+1)*PIX_W +: PIX_W];
      win_nx[(K*r+K-1)*PIX_W +: PIX_W] = col[r*PIX_W +: PIX_W];
    end
  end
  // a completing beat is only accepted when no window is pending, so the shift never clobbers one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win <= '0;
      cnt <= '0;
      idx <= '0;
      out_col <= '0;
      out_valid <= 1'b0;
    end else begin
      if (line_start) begin
        cnt <= '0;
        idx <= '0;
      end
      if (done) begin
        win <= win_nx;
        cnt <= cnt_nx;
        idx <= idx == 7'(IMG_W - 1) ? 7'd0 : idx + 7'd1;
        if (cnt_nx == 2'd3) out_col <= idx;
      end
      out_valid <= done ? cnt_nx == 2'd3 : out_valid && !out_ready;
    end
endmodule

// File: tb/tb_conv_window_assembler.sv
// tb_conv_window_assembler: directed checks of window assembly, padding, backpressure, errors and reset.
module tb_conv_window_assembler;
  logic clk = 0, rst = 1, in_valid = 0, in_zero = 0, in_sol = 0, out_ready = 1;
  logic [7:0] in_pix = 0;
  logic [1:0] in_row = 0;
  logic in_ready, out_valid, err;
  logic [71:0] out_win;
  logic [6:0] out_col;
  int checks = 0, failures = 0;

  conv_window_assembler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_zero(in_zero), .in_row(in_row), .in_sol(in_sol), .out_valid(out_valid),
    .out_ready(out_ready), .out_win(out_win), .out_col(out_col), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] win_of(int c0, int c1, int c2, bit z0);
    logic [71:0] w;
    int cs[3];
    cs = '{c0, c1, c2};
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[(3*r+k)*8 +: 8] = (z0 && k == 0) ? 8'd0 : 8'(10*cs[k] + r);
    return w;
  endfunction

  task automatic send_beat(input logic [7:0] p, input bit z, input logic [1:0] r, input bit s);
    @(negedge clk);
    in_valid = 1; in_pix = p; in_zero = z; in_row = r; in_sol = s;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL beat_timeout in_ready=%b required=1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 0; in_sol = 0; in_zero = 0;
  endtask

  task automatic send_col(input int c, input bit z, input bit s);
    for (int r = 0; r < 3; r++) send_beat(z ? 8'hFF : 8'(10*c + r), z, 2'(r), s && r == 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_win !== 72'd0) begin failures++; $display("FAIL rst_win got=%h exp=0", out_win); end
    checks++; if (out_col !== 7'd0) begin failures++; $display("FAIL rst_col got=%0d exp=0", out_col); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_line();
    do_reset(); out_ready = 1;
    send_col(0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL line_c0_valid got=%b exp=0", out_valid); end
    send_col(1, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL line_c1_valid got=%b exp=0", out_valid); end
    send_col(2, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL line_c2_valid got=%b exp=1", out_valid); end
    checks++; if (out_col !== 7'd2) begin failures++; $display("FAIL line_c2_col got=%0d exp=2", out_col); end
    checks++; if (out_win !== win_of(0, 1, 2, 0)) begin failures++; $display("FAIL line_c2_win got=%h exp=%h", out_win, win_of(0, 1, 2, 0)); end
    send_col(3, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL line_c3_valid got=%b exp=1", out_valid); end
    checks++; if (out_col !== 7'd3) begin failures++; $display("FAIL line_c3_col got=%0d exp=3", out_col); end
    checks++; if (out_win[23:0] !== {8'd30, 8'd20, 8'd10}) begin failures++; $display("FAIL line_c3_row0 got=%h exp=1e140a", out_win[23:0]); end
    checks++; if (out_win !== win_of(1, 2, 3, 0)) begin failures++; $display("FAIL line_c3_win got=%h exp=%h", out_win, win_of(1, 2, 3, 0)); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL line_drop_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero();
    do_reset(); out_ready = 1;
    send_col(0, 1, 1);
    send_col(1, 0, 0);
    send_col(2, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    checks++; if (out_win !== win_of(0, 1, 2, 1)) begin failures++; $display("FAIL zero_win got=%h exp=%h", out_win, win_of(0, 1, 2, 1)); end
  endtask

  task automatic test_backpressure();
    do_reset(); out_ready = 0;
    send_col(0, 0, 1);
    send_col(1, 0, 0);
    send_col(2, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_win !== win_of(0, 1, 2, 0) || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/1", i, out_win, out_valid, win_of(0, 1, 2, 0)); end
    end
    out_ready = 1;
    send_beat(8'd30, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    send_beat(8'd31, 0, 1, 0);
    send_beat(8'd32, 0, 2, 0);
    checks++; if (out_valid !== 1'b1 || out_col !== 7'd3) begin failures++; $display("FAIL bp_next got=%b/%0d exp=1/3", out_valid, out_col); end
    checks++; if (out_win !== win_of(1, 2, 3, 0)) begin failures++; $display("FAIL bp_next_win got=%h exp=%h", out_win, win_of(1, 2, 3, 0)); end
  endtask

  task automatic test_err();
    do_reset(); out_ready = 1;
    send_beat(8'd1, 0, 0, 1);
    send_beat(8'd2, 0, 2, 0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
    send_col(0, 0, 1);
    send_col(1, 0, 0);
    send_col(2, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_col !== 7'd2) begin failures++; $display("FAIL err_recover got=%b/%0d exp=1/2", out_valid, out_col); end
    checks++; if (out_win !== win_of(0, 1, 2, 0)) begin failures++; $display("FAIL err_recover_win got=%h exp=%h", out_win, win_of(0, 1, 2, 0)); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
    do_reset();
    send_beat(8'd7, 0, 3, 0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_row3 got=%b exp=1", err); end
  endtask

  task automatic test_sol();
    do_reset(); out_ready = 1;
    send_col(0, 0, 1);
    send_col(1, 0, 0);
    send_col(2, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sol_first got=%b exp=1", out_valid); end
    send_col(3, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sol_c0 got=%b exp=0", out_valid); end
    send_col(4, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sol_c1 got=%b exp=0", out_valid); end
    send_col(5, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_col !== 7'd2) begin failures++; $display("FAIL sol_c2 got=%b/%0d exp=1/2", out_valid, out_col); end
    checks++; if (out_win !== win_of(3, 4, 5, 0)) begin failures++; $display("FAIL sol_win got=%h exp=%h", out_win, win_of(3, 4, 5, 0)); end
  endtask

  task automatic test_rst_mid();
    do_reset(); out_ready = 0;
    send_beat(8'd9, 0, 1, 0);
    send_col(0, 0, 1);
    send_col(1, 0, 0);
    send_col(2, 0, 0);
    checks++; if (out_valid !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b/%b exp=1/1", out_valid, err); end
    @(negedge clk); rst = 1; #1;
    checks++; if (out_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%b exp=0/0", out_valid, err); end
    checks++; if (out_win !== 72'd0 || out_col !== 7'd0) begin failures++; $display("FAIL mid_clear got=%h/%0d exp=0/0", out_win, out_col); end
    @(negedge clk); rst = 0; out_ready = 1;
    send_beat(8'd50, 0, 0, 1);
    send_beat(8'd51, 0, 1, 0);
    do_reset();
    send_col(0, 0, 1);
    checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_fresh0 got=%b/%b exp=0/0", err, out_valid); end
    send_col(1, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_fresh1 got=%b exp=0", out_valid); end
    send_col(2, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_col !== 7'd2) begin failures++; $display("FAIL mid_fresh2 got=%b/%0d exp=1/2", out_valid, out_col); end
    checks++; if (out_win !== win_of(0, 1, 2, 0)) begin failures++; $display("FAIL mid_win got=%h exp=%h", out_win, win_of(0, 1, 2, 0)); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_zero();
    test_backpressure();
    test_err();
    test_sol();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
